registro_etapa_skid: RTL and testbench
======================================

// Module: registro_etapa_skid
// PURPOSE
//  Parametrised pipeline stage register with valid/ready handshake, 2-entry skid buffer,
//  flush (bubble insertion) and a bubble counter. Replaces the fixed ID/EXE-style latch.
//  Sits between any two stages of the vector processor (ID->EXE, EXE->MEM, MEM->WB).
//  Carries one control bundle and one data bundle per beat. Sustains full throughput
//  under backpressure with no combinational ready path from out_ready to in_ready.
// PARAMETERS
//  DATA_W  104  width of data bundle (default: VEC1,VEC2,VFS 32b + sca1 8b)
//  CTRL_W  20   width of control bundle (EXE/MEM/WB control bits)
//  CNT_W   16   width of bubble_cnt
// PORTS
//  clk         in   1       clock; all logic on posedge
//  rst         in   1       synchronous reset, active high
//  flush       in   1       discard all held beats; stage becomes empty
//  in_valid    in   1       upstream beat present
//  in_ready    out  1       stage can accept a beat this cycle
//  in_ctrl     in   CTRL_W  upstream control bundle
//  in_data     in   DATA_W  upstream data bundle
//  out_valid   out  1       beat present on out_*
//  out_ready   in   1       downstream accepts beat this cycle
//  out_ctrl    out  CTRL_W  control bundle; forced to 0 when out_valid=0
//  out_data    out  DATA_W  data bundle; holds the last value when out_valid=0
//  occupancy   out  2       number of held beats: 0, 1 or 2
//  bubble_cnt  out  CNT_W   count of cycles with out_valid=0 since reset; saturates
// BEHAVIOUR
//  - One clock; reset is synchronous and active high. On rst: state EMPTY, out_valid=0,
//    out_ctrl=0, out_data=0, skid regs=0, occupancy=0, bubble_cnt=0, in_ready=1.
//  - acc = in_valid & in_ready; take = out_valid & out_ready.
//  - States: EMPTY (occ 0), FULL (main reg valid, occ 1), SKID (main+skid valid, occ 2).
//  - in_ready = (state != SKID). It is decoded from state regs only and never depends on out_ready.
//  - EMPTY: acc -> FULL, main<=in. Otherwise stay.
//  - FULL: acc&take -> FULL, main<=in. acc&!take -> SKID, skid<=in. !acc&take -> EMPTY.
//    Neither -> hold.
//  - SKID: take -> FULL, main<=skid. Otherwise hold. No accepts, because in_ready=0.
//  - Ordering is strictly FIFO. A beat is never duplicated or lost, except by flush.
//  - Latency: a beat accepted in cycle N appears on out_* in cycle N+1 when the stage was
//    EMPTY, or was FULL with take.
//  - out_valid=1 in FULL and SKID. out_ctrl = out_valid ? main_ctrl : 0, so bubbles
//    never assert reg_wr/mem_wr.
//  - flush (priority below rst, above all else): next state EMPTY. A beat accepted in the
//    flush cycle is consumed and discarded. A take in the flush cycle still completes,
//    since the current beat was visible. out_data is not cleared by flush.
//  - bubble_cnt: +1 each cycle with out_valid=0, including the cycle after flush. Holds
//    at 2^CNT_W-1. Cleared by rst only.
//  - All outputs are registered except in_ready and out_ctrl gating, which are decoded
//    from regs.
// TESTING
//  1) Reset, then in_valid=1 with ctrl=0x00001 and data=0xA each cycle, out_ready=1 ->
//     out_valid rises 1 cycle later. One beat per cycle in order. occupancy=1.
//  2) FULL holding A; out_ready=0; send B -> occupancy=2, in_ready=0. Raise out_ready ->
//     A then B appear on consecutive cycles. in_ready=1 the cycle after A is taken.
//  3) SKID holding A,B; flush=1 with in_valid=1 (C) -> next cycle out_valid=0, out_ctrl=0,
//     occupancy=0. C never appears.
//  4) out_ready toggled randomly, 1000 beats with ctrl=i, data=i -> scoreboard sees 0..999
//     exactly once in order. in_ready never depends on same-cycle out_ready.
//  5) CNT_W=4, idle 20 cycles after reset -> bubble_cnt=15 and holds. Flush does not clear it.
//  6) rst asserted while in SKID -> next cycle occupancy=0, out_valid=0, out_data=0,
//     in_ready=1.

Source files
------------

// File: rtl/registro_etapa_skid.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer, flush and bubble counter.
// Latency: 1 cycle from accept to out_* when the stage is empty, or full and being drained.
// Backpressure: in_ready comes only from state regs; the skid slot absorbs the beat in flight when out_ready drops.
module registro_etapa_skid #(
    parameter int DATA_W = 104,
    parameter int CTRL_W = 20,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CTRL_W-1:0] main_ctrl;
    logic [DATA_W-1:0] main_data;
    logic [CTRL_W-1:0] skid_ctrl;
    logic [DATA_W-1:0] skid_data;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;
    logic              acc;
    logic              take;

    // Handshake decode; in_ready is a pure function of the state register.
    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign acc       = in_valid & in_ready;
    assign take      = out_valid & out_ready;
    // Bubbles carry an all-zero control bundle so no write enable leaks downstream.
    assign out_ctrl  = out_valid ? main_ctrl : '0;
    assign out_data  = main_data;

    // Next-state and register load selection; flush overrides every transition.
    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        unique case (state)
            ST_EMPTY: begin
                if (acc) begin
                    state_nxt    = ST_FULL;
                    load_main_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (acc && take) begin
                    load_main_in = 1'b1;
                end else if (acc) begin
                    state_nxt = ST_SKID;
                    load_skid = 1'b1;
                end else if (take) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_SKID: begin
                if (take) begin
                    state_nxt      = ST_FULL;
                    load_main_skid = 1'b1;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
        // Anything accepted this cycle is dropped; out_data keeps the beat last shown.
        if (flush) begin
            state_nxt      = ST_EMPTY;
            load_main_in   = 1'b0;
            load_main_skid = 1'b0;
            load_skid      = 1'b0;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Main and skid payload registers; main refills from skid to keep FIFO order.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_ctrl <= '0;
            main_data <= '0;
            skid_ctrl <= '0;
            skid_data <= '0;
        end else begin
            if (load_main_in) begin
                main_ctrl <= in_ctrl;
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_ctrl <= skid_ctrl;
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_ctrl <= in_ctrl;
                skid_data <= in_data;
            end
        end
    end

    // Saturating count of cycles where the stage presented no beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt <= '0;
        end else if (!out_valid && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + CNT_W'(1);
        end
    end

    // Held-beat count decoded from state.
    always_comb begin
        occupancy = 2'd0;
        unique case (state)
            ST_EMPTY: occupancy = 2'd0;
            ST_FULL:  occupancy = 2'd1;
            ST_SKID:  occupancy = 2'd2;
            default:  occupancy = 2'd0;
        endcase
    end

endmodule

// File: tb/tb_registro_etapa_skid.sv
// Directed vector table, randomised backpressure scoreboard and counter saturation checks.
// Latency: inputs are driven before each edge, outputs sampled 1 time unit after it.
// Backpressure: out_ready driven by table entries or $urandom in the scoreboard phase.
module tb_registro_etapa_skid;

    logic         clk;
    logic         rst;
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [19:0]  in_ctrl;
    logic [103:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [19:0]  out_ctrl;
    logic [103:0] out_data;
    logic [1:0]   occupancy;
    logic [15:0]  bubble_cnt;

    // Second instance with a narrow counter for the saturation check.
    logic         rst4;
    logic         flush4;
    logic         in_valid4;
    logic         in_ready4;
    logic [19:0]  in_ctrl4;
    logic [103:0] in_data4;
    logic         out_valid4;
    logic         out_ready4;
    logic [19:0]  out_ctrl4;
    logic [103:0] out_data4;
    logic [1:0]   occupancy4;
    logic [3:0]   bubble_cnt4;

    int errors;
    int checks;

    registro_etapa_skid dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ctrl    (in_ctrl),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ctrl   (out_ctrl),
        .out_data   (out_data),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    registro_etapa_skid #(.CNT_W(4)) dut4 (
        .clk        (clk),
        .rst        (rst4),
        .flush      (flush4),
        .in_valid   (in_valid4),
        .in_ready   (in_ready4),
        .in_ctrl    (in_ctrl4),
        .in_data    (in_data4),
        .out_valid  (out_valid4),
        .out_ready  (out_ready4),
        .out_ctrl   (out_ctrl4),
        .out_data   (out_data4),
        .occupancy  (occupancy4),
        .bubble_cnt (bubble_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic         rst;
        logic         flush;
        logic         iv;
        logic [19:0]  ic;
        logic [103:0] id;
        logic         ordy;
        logic         ev;
        logic         eir;
        logic [19:0]  ec;
        logic [103:0] ed;
        logic [1:0]   eocc;
        logic [15:0]  ebub;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic f, input logic iv,
                                input logic [19:0] ic, input logic [103:0] id,
                                input logic ordy, input logic ev, input logic eir,
                                input logic [19:0] ec, input logic [103:0] ed,
                                input logic [1:0] eocc, input logic [15:0] ebub);
        vec_t v;
        v.rst = r;   v.flush = f; v.iv = iv; v.ic = ic; v.id = id; v.ordy = ordy;
        v.ev = ev;   v.eir = eir; v.ec = ec; v.ed = ed; v.eocc = eocc; v.ebub = ebub;
        return v;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    localparam logic [103:0] WIDE = 104'hF100_0000_0000_0000_0000_0000_10;

    vec_t vt [19];

    initial begin
        int tx;
        int rx;
        logic r0;
        logic r1;
        logic acc;
        logic take;

        errors = 0;
        checks = 0;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
        rst4 = 1'b0; flush4 = 1'b0; in_valid4 = 1'b0; in_ctrl4 = '0; in_data4 = '0; out_ready4 = 1'b0;

        //            rst flush iv  ic  id       ordy | ev eir ec  ed      occ bub
        vt[0]  = mk(1, 0, 0, 0,  0,     0,  0, 1, 0,  0,     0, 0);  // reset state
        vt[1]  = mk(0, 0, 1, 1,  'hA,   1,  1, 1, 1,  'hA,   1, 1);  // first beat, 1-cycle latency
        vt[2]  = mk(0, 0, 1, 2,  'hB,   1,  1, 1, 2,  'hB,   1, 1);  // streaming
        vt[3]  = mk(0, 0, 1, 3,  'hC,   1,  1, 1, 3,  'hC,   1, 1);
        vt[4]  = mk(0, 0, 1, 4,  'hD,   0,  1, 0, 3,  'hC,   2, 1);  // stall -> skid
        vt[5]  = mk(0, 0, 1, 5,  'hE,   0,  1, 0, 3,  'hC,   2, 1);  // E refused
        vt[6]  = mk(0, 0, 0, 0,  0,     1,  1, 1, 4,  'hD,   1, 1);  // C taken, D promoted
        vt[7]  = mk(0, 0, 0, 0,  0,     1,  0, 1, 0,  'hD,   0, 1);  // D taken, data held
        vt[8]  = mk(0, 0, 0, 0,  0,     1,  0, 1, 0,  'hD,   0, 2);  // bubble counted
        vt[9]  = mk(0, 0, 1, 9,  9,     0,  1, 1, 9,  9,     1, 3);
        vt[10] = mk(0, 0, 1, 10, 10,    0,  1, 0, 9,  9,     2, 3);  // skid full
        vt[11] = mk(0, 1, 1, 11, 11,    0,  0, 1, 0,  9,     0, 3);  // flush from skid
        vt[12] = mk(0, 0, 0, 0,  0,     0,  0, 1, 0,  9,     0, 4);  // counts after flush
        vt[13] = mk(0, 0, 1, 13, 13,    0,  1, 1, 13, 13,    1, 5);
        vt[14] = mk(0, 1, 1, 14, 14,    1,  0, 1, 0,  13,    0, 5);  // flush drops accepted beat
        vt[15] = mk(0, 0, 0, 0,  0,     0,  0, 1, 0,  13,    0, 6);
        vt[16] = mk(0, 0, 1, 16, WIDE,  0,  1, 1, 16, WIDE,  1, 7);
        vt[17] = mk(0, 0, 1, 17, 17,    0,  1, 0, 16, WIDE,  2, 7);
        vt[18] = mk(1, 0, 1, 18, 18,    0,  0, 1, 0,  0,     0, 0);  // reset from skid

        foreach (vt[i]) begin
            rst = vt[i].rst; flush = vt[i].flush; in_valid = vt[i].iv;
            in_ctrl = vt[i].ic; in_data = vt[i].id; out_ready = vt[i].ordy;
            tick();
            chk($sformatf("v%0d.out_valid", i), 128'(out_valid),  128'(vt[i].ev));
            chk($sformatf("v%0d.in_ready", i),  128'(in_ready),   128'(vt[i].eir));
            chk($sformatf("v%0d.out_ctrl", i),  128'(out_ctrl),   128'(vt[i].ec));
            chk($sformatf("v%0d.out_data", i),  128'(out_data),   128'(vt[i].ed));
            chk($sformatf("v%0d.occupancy", i), 128'(occupancy),  128'(vt[i].eocc));
            chk($sformatf("v%0d.bubble", i),    128'(bubble_cnt), 128'(vt[i].ebub));
        end

        // 1000 beats under random backpressure, scoreboarded in order.
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tx = 0;
        rx = 0;
        for (int cyc = 0; cyc < 20000 && rx < 1000; cyc++) begin
            in_valid = (tx < 1000) && ($urandom_range(0, 3) != 0);
            in_ctrl  = 20'(tx);
            in_data  = 104'(tx);
            out_ready = 1'b0;
            #1;
            r0 = in_ready;
            out_ready = 1'b1;
            #1;
            r1 = in_ready;
            chk("rnd.in_ready_indep", 128'(r1), 128'(r0));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("rnd.occupancy", 128'(occupancy), 128'(tx - rx));
            acc  = in_valid && in_ready;
            take = out_valid && out_ready;
            if (take) begin
                chk("rnd.out_ctrl", 128'(out_ctrl), 128'(rx));
                chk("rnd.out_data", 128'(out_data), 128'(rx));
                rx++;
            end
            if (acc) tx++;
            tick();
        end
        chk("rnd.drained", 128'(rx), 128'(1000));
        in_valid = 1'b0;
        out_ready = 1'b0;

        // Narrow counter: saturates at 15, survives flush, cleared only by reset.
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("cnt4.reset", 128'(bubble_cnt4), 128'(0));
        repeat (5) tick();
        chk("cnt4.five", 128'(bubble_cnt4), 128'(5));
        repeat (15) tick();
        chk("cnt4.sat", 128'(bubble_cnt4), 128'(15));
        flush4 = 1'b1;
        tick();
        flush4 = 1'b0;
        chk("cnt4.flush", 128'(bubble_cnt4), 128'(15));
        repeat (3) tick();
        chk("cnt4.hold", 128'(bubble_cnt4), 128'(15));
        rst4 = 1'b1;
        tick();
        rst4 = 1'b0;
        chk("cnt4.rst", 128'(bubble_cnt4), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
